sync_fifo_flags: RTL



---
 rtl/sync_fifo_flags.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, registered threshold flags, flush and
// sticky overflow/underflow. FWFT selects registered or fall-through read data.
module sync_fifo_flags #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 128,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4,
  parameter int FWFT      = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     WR_EN,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     RD_EN,
  input  logic                     flush,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         data_out,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic             full_q;
  logic             empty_q;
  logic             af_q;
  logic             ae_q;
  logic             overflow_q;
  logic             underflow_q;
  logic             rd_acc;
  logic             wr_acc;
  logic             wr_commit;
  logic             rd_commit;
  logic             ovf_set;
  logic             udf_set;

  // Acceptance uses pre-edge flags; a read frees a slot for a write at full.
  assign rd_acc    = RD_EN && !empty_q;
  assign wr_acc    = WR_EN && (!full_q || rd_acc);
  assign wr_commit = wr_acc && !flush;
  assign rd_commit = rd_acc && !flush;
  assign ovf_set   = !flush && WR_EN && !wr_acc;
  assign udf_set   = !flush && RD_EN && !rd_acc;

  always_comb begin
    cnt_next = cnt;
    if (flush) begin
      cnt_next = '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   cnt_next = cnt + CW'(1);
        2'b01:   cnt_next = cnt - CW'(1);
        default: cnt_next = cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
        if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      end
      cnt         <= cnt_next;
      full_q      <= (cnt_next == DEPTH_C);
      empty_q     <= (cnt_next == '0);
      af_q        <= (cnt_next >= AF_C);
      ae_q        <= (cnt_next <= AE_C);
      // A new error in the same cycle as clr_err keeps the flag set.
      overflow_q  <= ovf_set | (overflow_q  & !clr_err);
      underflow_q <= udf_set | (underflow_q & !clr_err);
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_commit) mem[wr_ptr] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = mem[rd_ptr];
      assign rd_valid = !empty_q;
    end else begin : g_reg
      logic [WIDTH-1:0] dout_q;
      logic             rv_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          dout_q <= '0;
          rv_q   <= 1'b0;
        end else begin
          rv_q <= rd_commit;
          if (rd_commit) dout_q <= mem[rd_ptr];
        end
      end

      assign data_out = dout_q;
      assign rd_valid = rv_q;
    end
  endgenerate

  assign count        = cnt;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
